// File: rtl/lift_pkg.sv
// Shared types and constants for the smartlift request scheduler.
package lift_pkg;

    localparam int unsigned FloorW        = 4;
    localparam int unsigned DefaultFloors = 9;

    typedef enum logic [1:0] {
        StIdle,
        StMoving,
        StDoor
    } lift_state_e;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

endpackage

// File: rtl/lift_timer.sv
// Loadable down-counter; done pulses for one cycle, Cycles edges after the load edge.
module lift_timer #(
    parameter int unsigned Cycles = 4
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic load,
    output logic done
);

    localparam int unsigned CntW = $clog2(Cycles);

    logic [CntW-1:0] cnt_q;
    logic            run_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (load) begin
            cnt_q <= CntW'(Cycles - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign done = run_q && (cnt_q == '0);

endmodule

// File: rtl/lift_scheduler.sv
// SCAN-policy lift scheduler: collects floor calls and sequences travel and door.
// Optional door hold input is enabled by defining LIFT_DOOR_HOLD_EN.
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int unsigned N_FLOORS      = DefaultFloors,
    parameter int unsigned TRAVEL_CYCLES = 50_000_000,
    parameter int unsigned DOOR_CYCLES   = 150_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [N_FLOORS-1:0] req_cab,
    input  logic [N_FLOORS-1:0] req_hall,
`ifdef LIFT_DOOR_HOLD_EN
    input  logic                door_hold,
`endif
    output logic [FloorW-1:0]   cur_floor,
    output logic [1:0]          dir,
    output logic                moving,
    output logic                door_open,
    output logic [N_FLOORS-1:0] pending
);

    lift_state_e         state_q, state_d;
    dir_e                last_dir_q, last_dir_d;
    dir_e                dir_q, dir_d;
    logic [FloorW-1:0]   floor_q, floor_d, next_floor;
    logic [N_FLOORS-1:0] pend_q, pend_d;
    logic [N_FLOORS-1:0] reqs, clr, absorb;
    logic [N_FLOORS-1:0] above_cur, below_cur, at_cur, above_nxt, below_nxt, at_nxt;
    logic                moving_q, door_q;
    logic                req_here_q, req_here_d;
    logic                calls_fwd, calls_rev, ahead_nxt, here, arrive, hit_cur;
    logic                travel_load, travel_done, door_load, door_done, hold;

`ifdef LIFT_DOOR_HOLD_EN
    assign hold = door_hold;
`else
    assign hold = 1'b0;
`endif

    assign reqs = req_cab | req_hall;

    always_comb begin
        next_floor = floor_q;
        if (last_dir_q == DIR_UP && floor_q < FloorW'(N_FLOORS - 1)) begin
            next_floor = floor_q + 1'b1;
        end else if (last_dir_q == DIR_DOWN && floor_q != '0) begin
            next_floor = floor_q - 1'b1;
        end
    end

    always_comb begin
        above_cur = '0;
        below_cur = '0;
        at_cur    = '0;
        above_nxt = '0;
        below_nxt = '0;
        at_nxt    = '0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            above_cur[i] = i > int'(floor_q);
            below_cur[i] = i < int'(floor_q);
            at_cur[i]    = i == int'(floor_q);
            above_nxt[i] = i > int'(next_floor);
            below_nxt[i] = i < int'(next_floor);
            at_nxt[i]    = i == int'(next_floor);
        end
    end

    always_comb begin
        if (last_dir_q == DIR_UP) begin
            calls_fwd = |(pend_q & above_cur);
            calls_rev = |(pend_q & below_cur);
            ahead_nxt = |(pend_q & above_nxt);
        end else begin
            calls_fwd = |(pend_q & below_cur);
            calls_rev = |(pend_q & above_cur);
            ahead_nxt = |(pend_q & below_nxt);
        end
    end

    // A call for the idle car's own floor is held in req_here_q rather than pending.
    assign here    = |(pend_q & at_cur) | req_here_q;
    assign arrive  = |(pend_q & at_nxt);
    assign hit_cur = |(reqs & at_cur);

    always_comb begin
        state_d     = state_q;
        last_dir_d  = last_dir_q;
        floor_d     = floor_q;
        clr         = '0;
        travel_load = 1'b0;
        door_load   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (here) begin
                    clr       = at_cur;
                    state_d   = StDoor;
                    door_load = 1'b1;
                end else if (calls_fwd) begin
                    state_d     = StMoving;
                    travel_load = 1'b1;
                end else if (calls_rev) begin
                    state_d     = StMoving;
                    travel_load = 1'b1;
                    last_dir_d  = (last_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                end
            end
            StMoving: begin
                if (travel_done) begin
                    floor_d = next_floor;
                    if (next_floor == floor_q) begin
                        state_d = StIdle;
                    end else if (arrive) begin
                        clr       = at_nxt;
                        state_d   = StDoor;
                        door_load = 1'b1;
                    end else if (ahead_nxt) begin
                        travel_load = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDoor: begin
                if (hit_cur || hold) begin
                    door_load = 1'b1;
                end else if (door_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Own-floor calls vanish when the door is (or is about to be) open for them.
    assign absorb = (state_q == StDoor || (state_q == StIdle && state_d != StMoving)) ?
                    at_cur : '0;
    assign pend_d     = (pend_q | (reqs & ~absorb)) & ~clr;
    assign req_here_d = (state_q == StIdle) && (state_d == StIdle) && hit_cur;
    assign dir_d      = (state_d == StMoving) ? last_dir_d : DIR_STOP;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= StIdle;
            last_dir_q <= DIR_UP;
            dir_q      <= DIR_STOP;
            floor_q    <= '0;
            pend_q     <= '0;
            req_here_q <= 1'b0;
            moving_q   <= 1'b0;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
            dir_q      <= dir_d;
            floor_q    <= floor_d;
            pend_q     <= pend_d;
            req_here_q <= req_here_d;
            moving_q   <= (state_d == StMoving);
            door_q     <= (state_d == StDoor);
        end
    end

    lift_timer #(
        .Cycles (TRAVEL_CYCLES)
    ) u_travel_timer (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .load     (travel_load),
        .done     (travel_done)
    );

    lift_timer #(
        .Cycles (DOOR_CYCLES)
    ) u_door_timer (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .load     (door_load),
        .done     (door_done)
    );

    assign cur_floor = floor_q;
    assign dir       = dir_q;
    assign moving    = moving_q;
    assign door_open = door_q;
    assign pending   = pend_q;

endmodule

// File: tb/tb_lift_scheduler.sv
// Scoreboard bench for lift_scheduler: expected motion/door events are queued per scenario.
module tb_lift_scheduler;

    localparam int unsigned NF = 9;

    localparam logic [7:0] EvMove  = 8'd1;
    localparam logic [7:0] EvFloor = 8'd2;
    localparam logic [7:0] EvOpen  = 8'd3;
    localparam logic [7:0] EvClose = 8'd4;

    logic          CLOCK_50 = 1'b0;
    logic          RESET_N;
    logic [NF-1:0] req_cab, req_hall;
    logic          door_hold;
    logic [3:0]    cur_floor;
    logic [1:0]    dir;
    logic          moving, door_open;
    logic [NF-1:0] pending;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            edge_cnt = 0;
    logic          mon_en = 1'b0;
    logic          prev_mv = 1'b0, prev_dr = 1'b0;
    logic [3:0]    prev_fl = '0;
    logic [47:0]   exp_q[$];

    lift_scheduler #(
        .N_FLOORS      (NF),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET_N   (RESET_N),
        .req_cab   (req_cab),
        .req_hall  (req_hall),
`ifdef LIFT_DOOR_HOLD_EN
        .door_hold (door_hold),
`endif
        .cur_floor (cur_floor),
        .dir       (dir),
        .moving    (moving),
        .door_open (door_open),
        .pending   (pending)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_evt(input logic [7:0] kind, input int fl, input int cyc);
        exp_q.push_back({kind, 8'(fl), 32'(cyc)});
    endtask

    task automatic got_evt(input string tag, input logic [7:0] kind);
        logic [47:0] obs;
        obs = {kind, 4'b0, cur_floor, 32'(edge_cnt)};
        if (exp_q.size() == 0) chk({tag, "_extra"}, obs, 48'h0);
        else chk(tag, obs, exp_q.pop_front());
    endtask

    // Event monitor: sampled on the falling edge, compared against the queue head.
    always @(negedge CLOCK_50) begin
        if (mon_en) begin
            if (moving && !prev_mv) got_evt("ev_move", EvMove);
            if (cur_floor != prev_fl) got_evt("ev_floor", EvFloor);
            if (door_open && !prev_dr) got_evt("ev_open", EvOpen);
            if (!door_open && prev_dr) got_evt("ev_close", EvClose);
        end
        prev_mv <= moving;
        prev_dr <= door_open;
        prev_fl <= cur_floor;
    end

    task automatic next_edge();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_edge(input int e);
        while (edge_cnt < e) next_edge();
    endtask

    // Called 1ns after an edge; the request is sampled on the following edge k.
    task automatic drive_req(input logic [NF-1:0] cab, input logic [NF-1:0] hall, output int k);
        req_cab  = cab;
        req_hall = hall;
        next_edge();
        k        = edge_cnt;
        req_cab  = '0;
        req_hall = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_floor"}, cur_floor, 0);
        chk({tag, "_dir"}, dir, 0);
        chk({tag, "_moving"}, moving, 0);
        chk({tag, "_door"}, door_open, 0);
        chk({tag, "_pending"}, pending, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish (edge %0d)", edge_cnt);
        $fatal(1);
    end

    initial begin
        int k, k2;
        RESET_N   = 1'b0;
        req_cab   = '0;
        req_hall  = '0;
        door_hold = 1'b0;
        repeat (2) next_edge();
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        next_edge();
        mon_en = 1'b1;
        next_edge();

        // Call for the idle car's own floor: door opens, pending never shows it.
        drive_req('0, 9'h001, k);
        push_evt(EvOpen, 0, k + 1);
        push_evt(EvClose, 0, k + 7);
        @(negedge CLOCK_50);
        chk("pend_absorb", pending, 0);
        wait_edge(k + 9);

        // Single cabin call to floor 3.
        drive_req(9'h008, '0, k);
        push_evt(EvMove, 0, k + 1);
        push_evt(EvFloor, 1, k + 5);
        push_evt(EvFloor, 2, k + 9);
        push_evt(EvFloor, 3, k + 13);
        push_evt(EvOpen, 3, k + 13);
        push_evt(EvClose, 3, k + 19);
        @(negedge CLOCK_50);
        chk("pend_set", pending, 9'h008);
        @(negedge CLOCK_50);
        chk("dir_up", dir, 2'b01);
        chk("moving_up", moving, 1);
        wait_edge(k + 22);
        @(negedge CLOCK_50);
        chk("pend_idle", pending, 0);
        chk("dir_stop", dir, 0);
        next_edge();

        // Reset mid-travel at floor 6 with calls outstanding.
        drive_req(9'h100, 9'h002, k);
        push_evt(EvMove, 3, k + 1);
        push_evt(EvFloor, 4, k + 5);
        push_evt(EvFloor, 5, k + 9);
        push_evt(EvFloor, 6, k + 13);
        wait_edge(k + 14);
        mon_en = 1'b0;
        #2 RESET_N = 1'b0;
        #1 chk_reset_vals("rst_mid");
        next_edge();
        next_edge();
        RESET_N = 1'b1;
        repeat (8) next_edge();
        @(negedge CLOCK_50);
        chk_reset_vals("post_rst");
        next_edge();
        mon_en = 1'b1;

        // SCAN: head for 5, pick up 2 on the way, then reverse for 1.
        drive_req(9'h020, '0, k);
        push_evt(EvMove, 0, k + 1);
        push_evt(EvFloor, 1, k + 5);
        push_evt(EvFloor, 2, k + 9);
        push_evt(EvOpen, 2, k + 9);
        push_evt(EvClose, 2, k + 15);
        push_evt(EvMove, 2, k + 16);
        push_evt(EvFloor, 3, k + 20);
        push_evt(EvFloor, 4, k + 24);
        push_evt(EvFloor, 5, k + 28);
        push_evt(EvOpen, 5, k + 28);
        push_evt(EvClose, 5, k + 34);
        push_evt(EvMove, 5, k + 35);
        push_evt(EvFloor, 4, k + 39);
        push_evt(EvFloor, 3, k + 43);
        push_evt(EvFloor, 2, k + 47);
        push_evt(EvFloor, 1, k + 51);
        push_evt(EvOpen, 1, k + 51);
        push_evt(EvClose, 1, k + 57);
        wait_edge(k + 5);
        drive_req(9'h006, '0, k2);
        @(negedge CLOCK_50);
        chk("pend_while_moving", pending, 9'h026);
        wait_edge(k + 36);
        @(negedge CLOCK_50);
        chk("dir_down", dir, 2'b10);
        wait_edge(k + 59);
        @(negedge CLOCK_50);
        chk("scan_pend_end", pending, 0);
        chk("scan_floor_end", cur_floor, 1);
        next_edge();

        // Door restart by a call for the open floor.
        drive_req(9'h010, '0, k);
        push_evt(EvMove, 1, k + 1);
        push_evt(EvFloor, 2, k + 5);
        push_evt(EvFloor, 3, k + 9);
        push_evt(EvFloor, 4, k + 13);
        push_evt(EvOpen, 4, k + 13);
        push_evt(EvClose, 4, k + 22);
        wait_edge(k + 15);
        drive_req('0, 9'h010, k2);
        @(negedge CLOCK_50);
        chk("pend_restart", pending, 0);
        wait_edge(k + 25);
        @(negedge CLOCK_50);
        chk("door_shut", door_open, 0);
        next_edge();

`ifdef LIFT_DOOR_HOLD_EN
        drive_req('0, 9'h010, k);
        push_evt(EvOpen, 4, k + 1);
        push_evt(EvClose, 4, k + 27);
        wait_edge(k + 1);
        door_hold = 1'b1;
        wait_edge(k + 21);
        door_hold = 1'b0;
        wait_edge(k + 30);
`endif

        @(negedge CLOCK_50);
        chk("evt_left", 48'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
